// File: rtl/tile_writeback_unit.sv
// rtl/tile_writeback_unit.sv - tile capture FIFO and activation-SRAM writeback; optional TILE_WB_DROP_COUNT_EN adds drop_count
module tile_writeback_unit #(
  parameter int  MAX_N      = 64,
  parameter int  ADDR_W     = 16,
  parameter int  FIFO_DEPTH = 4,
  localparam int CW         = $clog2(MAX_N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [127:0]      in_data,
  input  logic [CW-1:0]     in_row,
  input  logic [CW-1:0]     in_col,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] tiles_per_row,
  input  logic              layer_done,
  input  logic              clear_status,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic              mem_ready,
  output logic              wb_done,
  output logic              idle,
  output logic              overflow
`ifdef TILE_WB_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [127:0]      data_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, head_ptr;
  logic [PW:0]       count, remain;
  logic              full, pop, push, drop, load, fifo_idle;
  logic [ADDR_W-1:0] push_addr;
  logic              next_we;
  logic [ADDR_W-1:0] next_addr;
  logic [127:0]      next_data;

  // The entry being written stays in the queue until the memory takes it,
  // so the outstanding write occupies one of the FIFO_DEPTH slots.
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign pop       = mem_we && mem_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  assign load      = !mem_we || pop;
  assign remain    = count - (PW+1)'(pop);
  assign head_ptr  = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign fifo_idle = (count == '0) && !mem_we;

  // Word address of the tile: one word per 4x4 tile, wrapping at ADDR_W bits.
  assign push_addr = base_addr + ADDR_W'(in_row >> 2) * tiles_per_row + ADDR_W'(in_col >> 2);

  // Pick what the write port shows next: the surviving head, else a tile
  // arriving into an empty queue (bypass gives the one-cycle latency).
  always_comb begin
    next_we   = 1'b0;
    next_addr = push_addr;
    next_data = in_data;
    if (remain != '0) begin
      next_we   = 1'b1;
      next_addr = addr_mem[head_ptr];
      next_data = data_mem[head_ptr];
    end else if (push) begin
      next_we   = 1'b1;
    end
  end

  // Queue storage; contents are meaningless outside the count window so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Registered write port: held while stalled, reloaded on acceptance or when free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      mem_we <= next_we;
      if (next_we) begin
        mem_addr  <= next_addr;
        mem_wdata <= next_data;
      end
    end
  end

  // Layer sequencing state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Layer sequencing: a tile arriving during flush keeps us flushing so it
  // lands before wb_done.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (layer_done)    state_nxt = ST_FLUSH;
        else if (in_valid) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (layer_done) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (fifo_idle && !in_valid) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign wb_done = (state == ST_DONE);
  assign idle    = (count == '0) && !mem_we && (state == ST_IDLE);

  // Sticky drop flag; clear wins over a drop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (clear_status) overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
  end

`ifdef TILE_WB_DROP_COUNT_EN
  // Saturating count of dropped tiles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              drop_count <= '0;
    else if (clear_status)                  drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tile_writeback_unit.sv
// tb/tb_tile_writeback_unit.sv - directed and randomized check of tile_writeback_unit against a queue model
module tb_tile_writeback_unit;

  localparam int CW    = 7;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [127:0]  in_data;
  logic [CW-1:0] in_row, in_col;
  logic [15:0]   base_addr, tiles_per_row;
  logic          layer_done, clear_status, mem_ready;
  logic          mem_we, wb_done, idle, overflow;
  logic [15:0]   mem_addr;
  logic [127:0]  mem_wdata;
`ifdef TILE_WB_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  tile_writeback_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_row(in_row), .in_col(in_col), .base_addr(base_addr),
    .tiles_per_row(tiles_per_row), .layer_done(layer_done),
    .clear_status(clear_status), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .wb_done(wb_done),
    .idle(idle), .overflow(overflow)
`ifdef TILE_WB_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } ent_t;

  ent_t q[$];
  int   mstate;      // 0 idle, 1 active, 2 flushing, 3 done pulse
  bit   exp_ov;
  int   exp_dc;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   wr0;
  logic [127:0] d1;
  logic [15:0]  first_addr;

  function automatic logic [15:0] ref_addr(input logic [15:0] b, input logic [15:0] tpr,
                                           input int row, input int col);
    int unsigned s;
    s = int'(b) + (row / 4) * int'(tpr) + col / 4;
    return s[15:0];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    mstate = 0;
    exp_ov = 0;
    exp_dc = 0;
  endtask

  task automatic check_outputs();
    check("mem_we", mem_we, q.size() > 0);
    if (q.size() > 0) begin
      check("mem_addr", mem_addr, q[0].addr);
      check("mem_wdata", mem_wdata, q[0].data);
    end
    check("wb_done", wb_done, mstate == 3);
    check("idle", idle, (q.size() == 0) && (mstate == 0));
    check("overflow", overflow, exp_ov);
`ifdef TILE_WB_DROP_COUNT_EN
    check("drop_count", drop_count, exp_dc);
`endif
  endtask

  // Model of one clock edge given the currently driven inputs.
  task automatic model_edge();
    int   sz;
    bit   pop, push, drop;
    ent_t e;
    sz   = q.size();
    pop  = (sz > 0) && mem_ready;
    push = in_valid && ((sz < DEPTH) || pop);
    drop = in_valid && !push;
    case (mstate)
      0: if (layer_done) mstate = 2; else if (in_valid) mstate = 1;
      1: if (layer_done) mstate = 2;
      2: if (sz == 0 && !in_valid) mstate = 3;
      default: mstate = 0;
    endcase
    if (pop) q.pop_front();
    if (push) begin
      e.addr = ref_addr(base_addr, tiles_per_row, int'(in_row), int'(in_col));
      e.data = in_data;
      q.push_back(e);
    end
    if (clear_status) begin
      exp_ov = 0;
      exp_dc = 0;
    end else if (drop) begin
      exp_ov = 1;
      if (exp_dc < 65535) exp_dc++;
    end
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic cycle(input bit v, input int row, input int col, input logic [127:0] d,
                       input bit ld, input bit rdy, input bit clr);
    in_valid     = v;
    in_row       = CW'(row);
    in_col       = CW'(col);
    in_data      = d;
    layer_done   = ld;
    mem_ready    = rdy;
    clear_status = clr;
    @(negedge clk);
    check_outputs();
    if (mem_we && mem_ready) wr_count++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tile(input bit rdy);
    cycle(1, $urandom_range(0, 64), $urandom_range(0, 64),
          {$urandom, $urandom, $urandom, $urandom}, 0, rdy, 0);
  endtask

  task automatic quiet(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, rdy, 0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_data = '0; in_row = '0; in_col = '0;
    base_addr = '0; tiles_per_row = '0;
    layer_done = 0; clear_status = 0; mem_ready = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_wb_done", wb_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_idle", idle, 1'b1);
    reset = 1'b0;

    // single tile, one-cycle latency, wb_done after the write
    base_addr = 16'h0100; tiles_per_row = 16'd4;
    d1 = 128'h00112233445566778899AABBCCDDEEFF;
    cycle(1, 8, 4, d1, 0, 1, 0);
    check("single_we", mem_we, 1'b1);
    check("single_addr", mem_addr, 16'h0109);
    check("single_data", mem_wdata, d1);
    cycle(0, 0, 0, '0, 1, 1, 0);
    check("single_we_after", mem_we, 1'b0);
    check("single_done_early", wb_done, 1'b0);
    quiet(1, 1);
    check("single_done", wb_done, 1'b1);
    quiet(1, 1);
    check("single_done_pulse", wb_done, 1'b0);
    check("single_idle", idle, 1'b1);

    // backpressure: 4 tiles, ready low for 10 cycles
    wr0 = wr_count;
    base_addr = 16'h2000; tiles_per_row = 16'd9;
    tile(0);
    first_addr = q[0].addr;
    for (int i = 0; i < 3; i++) tile(0);
    quiet(6, 0);
    check("bp_stall_addr", mem_addr, first_addr);
    quiet(6, 1);
    check("bp_writes", wr_count - wr0, 4);
    check("bp_overflow", overflow, 1'b0);

    // overflow: fifth tile dropped, clear_status clears
    wr0 = wr_count;
    for (int i = 0; i < 5; i++) tile(0);
    check("ovf_set", overflow, 1'b1);
`ifdef TILE_WB_DROP_COUNT_EN
    check("ovf_count", drop_count, 16'd1);
`endif
    cycle(0, 0, 0, '0, 0, 0, 1);
    check("ovf_clear", overflow, 1'b0);
    quiet(6, 1);
    check("ovf_writes", wr_count - wr0, 4);

    // full queue with a pop in the same cycle as the push
    wr0 = wr_count;
    for (int i = 0; i < 4; i++) tile(0);
    tile(1);
    quiet(6, 1);
    check("fullpop_writes", wr_count - wr0, 5);
    check("fullpop_overflow", overflow, 1'b0);

    // address wrap
    base_addr = 16'hFFFF; tiles_per_row = 16'd3;
    cycle(1, 0, 4, {4{32'hA5A5_5A5A}}, 0, 0, 0);
    check("wrap_addr", mem_addr, 16'h0000);
    quiet(2, 1);

    // layer_done with empty queue: wb_done two cycles later
    cycle(0, 0, 0, '0, 1, 1, 0);
    check("min_done_t1", wb_done, 1'b0);
    quiet(1, 1);
    check("min_done_t2", wb_done, 1'b1);
    quiet(1, 1);

    // layer_done together with the last tile
    cycle(1, 4, 8, {4{32'h1234_5678}}, 1, 0, 0);
    quiet(3, 0);
    check("last_tile_no_done", wb_done, 1'b0);
    quiet(4, 1);

    // randomized traffic
    for (int l = 0; l < 4; l++) begin
      base_addr     = 16'($urandom);
      tiles_per_row = 16'($urandom_range(1, 40000));
      for (int i = 0; i < 150; i++)
        cycle($urandom_range(0, 1), $urandom_range(0, 64), $urandom_range(0, 64),
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 40) == 0);
      quiet(8, 1);
    end

    // reset mid-write with three tiles queued
    for (int i = 0; i < 3; i++) tile(0);
    check("pre_reset_we", mem_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("reset_async_we", mem_we, 1'b0);
    check("reset_idle", idle, 1'b1);
    reset_model();
    @(posedge clk);
    #1 reset = 1'b0;
    wr0 = wr_count;
    quiet(6, 1);
    check("post_reset_writes", wr_count - wr0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_writeback_unit.md
# tile_writeback_unit

Downstream neighbour of the systolic-array controller: captures each 128-bit packed output tile (16 int8 values plus base row/col) on its one-cycle valid strobe. Because the producer has no backpressure, tiles are queued in a small FIFO. Each tile's activation-memory word address is computed from its coordinates, and tiles are written one per word to activation SRAM over a valid/ready write port. The block also signals layer completion once all queued tiles have been written.

## Interface
- MAX_N, 64, max matrix dimension; coordinate width CW = $clog2(MAX_N+1)
- ADDR_W, 16, activation-memory word address width
- FIFO_DEPTH, 4, tile queue depth (power of two, ≥2)
- clk  input  1  clock; all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  tile strobe (array_out_valid from controller)
- in_data  input  128  packed tile, first chunk in MSBs
- in_row  input  CW  tile base row
- in_col  input  CW  tile base column
- base_addr  input  ADDR_W  layer output base word address; held stable during a layer
- tiles_per_row  input  ADDR_W  output words per tile-row of the layer
- layer_done  input  1  one-cycle pulse: producer has emitted its last tile
- clear_status  input  1  clears sticky overflow (and counter, if compiled)
- mem_we  output  1  write request
- mem_addr  output  ADDR_W  write word address
- mem_wdata  output  128  write data
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready
- wb_done  output  1  one-cycle pulse: layer fully written
- idle  output  1  FIFO empty, no write outstanding, FSM in IDLE
- overflow  output  1  sticky: a tile was dropped

## Operation
- Push: on in_valid, enqueue {addr, in_data}.
  - addr = base_addr + (in_row>>2)*tiles_per_row + (in_col>>2), computed at push.
  - Arithmetic at ADDR_W bits, wrap modulo 2^ADDR_W.
- Full FIFO: a push is accepted only if a pop occurs in the same cycle.
  - Otherwise the tile is dropped and overflow sets on the next edge.
- Pop: the FIFO head is loaded into registered mem_addr/mem_wdata with mem_we=1 whenever no write is outstanding.
  - Outputs hold stable until mem_we && mem_ready; then pop.
  - The next head, if any, is presented on the following cycle. Back-to-back accepted writes are allowed: at most one write per cycle, issued in strict FIFO order.
- FSM states:
  - IDLE: enter ACTIVE on in_valid.
  - ACTIVE: on layer_done go to FLUSH. A layer_done while in IDLE goes directly to FLUSH.
  - FLUSH: further in_valid is still accepted. When the FIFO is empty and no write is outstanding, go to DONE.
  - DONE: assert wb_done for one cycle, then return to IDLE.
- layer_done while already in FLUSH or DONE is ignored.
- A layer_done arriving in the same cycle as the last in_valid: that tile is written before wb_done.
- clear_status has priority over a same-cycle overflow event: the result is cleared.
- Reset mid-write:
  - The outstanding write is abandoned and mem_we drops asynchronously.
  - FIFO contents are discarded and the FSM returns to IDLE.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, wb_done=0, overflow=0, idle=1. FIFO empty, FSM IDLE.
- Latency: with the FIFO empty and no write outstanding, a tile strobed at edge t has mem_we=1 from cycle t+1.
  - With mem_ready held high, that tile is accepted at edge t+1.
- Throughput: one tile per cycle when mem_ready is held high.
- wb_done occurs no earlier than 1 cycle after the final accepted write.
  - Minimum: layer_done at t with the FIFO empty gives wb_done high in cycle t+2.
- idle is combinational from registered state. It is low in any cycle where the FIFO is non-empty, mem_we=1, or the FSM is not IDLE.

## Configuration
- TILE_WB_DROP_COUNT_EN defined:
  - Adds output drop_count (16 bits), which counts dropped tiles and saturates at 16'hFFFF.
  - Reset and clear_status zero it.
- Undefined: the port and counter are absent; only sticky overflow reports drops.

## Test plan
- Single tile, mem_ready=1:
  - Stimulus: base_addr=0x100, tiles_per_row=4, row=8, col=4, data=128'h0011…FF.
  - Response: mem_we=1 in cycle t+1, mem_addr=0x109, data matches; then layer_done gives wb_done 1 cycle after the write.
- Backpressure:
  - Stimulus: 4 tiles on consecutive cycles with mem_ready=0 for 10 cycles, then 1.
  - Response: 4 writes in order on 4 consecutive cycles, overflow=0, mem outputs stable while stalled.
- Overflow:
  - Stimulus: 5 tiles with mem_ready=0, FIFO_DEPTH=4.
  - Response: the 5th is dropped, overflow=1 (drop_count=1 if compiled); clear_status returns it to 0.
- Full with simultaneous pop:
  - Stimulus: FIFO full, mem_ready goes 1 in the same cycle as in_valid.
  - Response: no drop; 5 writes total.
- Address wrap:
  - Stimulus: base_addr=0xFFFF, row=0, col=4.
  - Response: mem_addr=0x0000.
- Reset mid-write:
  - Stimulus: assert reset while mem_we=1 and the FIFO holds 3 tiles.
  - Response: mem_we=0 immediately, idle=1, and no writes after deassert.
